// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing types and frame-buffer controller helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_CNT_W     = 11;
    localparam int FB_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2,
        DONE    = 2'd3
    } fb_state_t;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
    } vga_timing_t;

    // Stored pixels per bank for a given resolution and downscale.
    function automatic int fb_depth(input int h, input int v, input int s);
        return (h >> s) * (v >> s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA timing plus pixel colour bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if #(
    parameter int PIX_W = 12
);
    import vga_pkg::*;

    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
    logic [PIX_W-1:0]     rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface
`default_nettype wire

// File: rtl/fb_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fb_sdp_ram
//  Description : Simple dual-port RAM, one write port, registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_sdp_ram #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 12,
    localparam int c_aw  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic             clk,
    input  wire logic             i_we,
    input  wire logic [c_aw-1:0]  i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic [c_aw-1:0]  i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/vga_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_buffer_ctrl
//  Description : Double-buffered frame store with vblank-aligned swap/clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_buffer_ctrl
    import vga_pkg::*;
#(
    parameter  int               H_RES      = 1024,
    parameter  int               V_RES      = 768,
    parameter  int               SCALE_LOG2 = 1,
    parameter  int               PIX_W      = 12,
    parameter  logic [PIX_W-1:0] BG_RGB     = '0,
    localparam int c_stored_w = H_RES >> SCALE_LOG2,
    localparam int c_stored_h = V_RES >> SCALE_LOG2,
    localparam int c_depth    = fb_depth(H_RES, V_RES, SCALE_LOG2),
    localparam int c_x_w      = (c_stored_w > 1) ? $clog2(c_stored_w) : 1,
    localparam int c_y_w      = (c_stored_h > 1) ? $clog2(c_stored_h) : 1,
    localparam int c_idx_w    = (c_depth > 1) ? $clog2(c_depth) : 1,
    localparam int c_addr_w   = c_idx_w + 1,
    localparam int c_ram_dep  = 1 << c_addr_w
) (
    input  wire logic             clk,
    input  wire logic             rst,
    vga_if.in                     in,
    vga_if.out                    out,
    input  wire logic             wr_valid,
    output logic                  wr_ready,
    input  wire logic [c_x_w-1:0] wr_x,
    input  wire logic [c_y_w-1:0] wr_y,
    input  wire logic [PIX_W-1:0] wr_rgb,
    input  wire logic             swap_req,
    input  wire logic             clear_en,
    input  wire logic [PIX_W-1:0] clear_rgb,
    output logic                  swap_ack,
    output logic                  front_sel
);

    fb_state_t          r_state;
    fb_state_t          w_state_nxt;
    logic               r_front_sel;
    logic [c_idx_w-1:0] r_clr_cnt;
    logic               r_clr_en;
    logic [PIX_W-1:0]   r_clr_rgb;
    logic               r_vblnk_prev;
    logic               w_vb_start;
    logic               w_clr_last;
    logic               w_clr_we;

    assign w_vb_start = in.vblnk & ~r_vblnk_prev;
    assign w_clr_last = (r_clr_cnt == c_idx_w'(c_depth - 1));
    assign front_sel  = r_front_sel;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (swap_req)   w_state_nxt = PENDING;
            PENDING: if (w_vb_start) w_state_nxt = r_clr_en ? CLEAR : DONE;
            CLEAR:   if (w_clr_last) w_state_nxt = DONE;
            DONE:                    w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        swap_ack = 1'b0;
        w_clr_we = 1'b0;
        unique case (r_state)
            IDLE:    wr_ready = 1'b1;
            CLEAR:   w_clr_we = 1'b1;
            DONE:    swap_ack = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------- swap / clear control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_front_sel  <= 1'b0;
            r_clr_cnt    <= '0;
            r_clr_en     <= 1'b0;
            r_clr_rgb    <= '0;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_vblnk_prev <= in.vblnk;
            if (r_state == IDLE && swap_req) begin
                r_clr_en  <= clear_en;
                r_clr_rgb <= clear_rgb;
            end
            if (r_state == PENDING && w_vb_start) begin
                r_front_sel <= ~r_front_sel;
            end
            if (w_clr_we) begin
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + c_idx_w'(1);
            end
        end
    end

    // ----------------------------------------------------------- write path
    logic [c_idx_w-1:0]  w_wr_idx;
    logic                w_wr_in_range;
    logic                w_ram_we;
    logic [c_addr_w-1:0] w_ram_waddr;
    logic [PIX_W-1:0]    w_ram_wdata;

    assign w_wr_idx      = c_idx_w'(wr_y) * c_idx_w'(c_stored_w) + c_idx_w'(wr_x);
    assign w_wr_in_range = (int'(wr_x) < c_stored_w) && (int'(wr_y) < c_stored_h);

    // Clear and user writes are mutually exclusive because wr_ready is low in CLEAR.
    assign w_ram_we    = w_clr_we | (wr_valid & wr_ready & w_wr_in_range);
    assign w_ram_waddr = w_clr_we ? {~r_front_sel, r_clr_cnt} : {~r_front_sel, w_wr_idx};
    assign w_ram_wdata = w_clr_we ? r_clr_rgb : wr_rgb;

    // --------------------------------------------------------- display path
    logic [c_idx_w-1:0] w_rd_idx;
    logic               w_outside;
    logic [PIX_W-1:0]   w_rd_data;
    vga_timing_t        w_tim_in;
    vga_timing_t        r_tim_pipe [FB_RD_LATENCY];
    logic               r_outside_d1;
    logic               r_pipe_vld;
    logic [PIX_W-1:0]   r_rgb;
    logic               w_unused;

    assign w_rd_idx  = c_idx_w'(in.vcount >> SCALE_LOG2) * c_idx_w'(c_stored_w)
                     + c_idx_w'(in.hcount >> SCALE_LOG2);
    assign w_outside = (int'(in.hcount) >= H_RES) || (int'(in.vcount) >= V_RES);
    assign w_tim_in  = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                         vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk};
    assign w_unused  = ^in.rgb;

    fb_sdp_ram #(
        .DEPTH (c_ram_dep),
        .WIDTH (PIX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr ({r_front_sel, w_rd_idx}),
        .o_rdata (w_rd_data)
    );

    // r_pipe_vld masks the first RAM read after reset, whose address was never driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FB_RD_LATENCY; i++) begin
                r_tim_pipe[i] <= '0;
            end
            r_outside_d1 <= 1'b0;
            r_pipe_vld   <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_tim_pipe[0] <= w_tim_in;
            for (int i = 1; i < FB_RD_LATENCY; i++) begin
                r_tim_pipe[i] <= r_tim_pipe[i-1];
            end
            r_outside_d1 <= w_outside;
            r_pipe_vld   <= 1'b1;
            if (!r_pipe_vld || r_tim_pipe[0].hblnk || r_tim_pipe[0].vblnk) begin
                r_rgb <= '0;
            end else if (r_outside_d1) begin
                r_rgb <= BG_RGB;
            end else begin
                r_rgb <= w_rd_data;
            end
        end
    end

    assign out.hcount = r_tim_pipe[FB_RD_LATENCY-1].hcount;
    assign out.vcount = r_tim_pipe[FB_RD_LATENCY-1].vcount;
    assign out.hsync  = r_tim_pipe[FB_RD_LATENCY-1].hsync;
    assign out.vsync  = r_tim_pipe[FB_RD_LATENCY-1].vsync;
    assign out.hblnk  = r_tim_pipe[FB_RD_LATENCY-1].hblnk;
    assign out.vblnk  = r_tim_pipe[FB_RD_LATENCY-1].vblnk;
    assign out.rgb    = r_rgb;

endmodule
`default_nettype wire
